// File: rtl/merge_light_n_pkg.sv
// merge_light_n_pkg: shared widths and thermometer/popcount helpers for the cluster merger.
package merge_light_n_pkg;
  localparam int MXADRBITS_DEF = 11;
  localparam int MXCNTBITS_DEF = 3;
  function automatic int thermo_len(input logic [63:0] v, input int n);
    int len;
    logic run;
    len = 0;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      run = run & v[i] & (i < n);
      len += int'(run);
    end
    return len;
  endfunction
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/merge_light_n_if.sv
// merge_light_n_if: frame data in/out bundle of the merger; clock and reset stay outside.
interface merge_light_n_if import merge_light_n_pkg::*; #(
  parameter int MXADRBITS = MXADRBITS_DEF,
  parameter int MXCNTBITS = MXCNTBITS_DEF,
  parameter int NHALF = 8,
  parameter int NOUT = 8,
  parameter int MXOVFBITS = 16
) ();
  logic                          mux_pulse_in;
  logic [2*NHALF*MXADRBITS-1:0]  adr_in;
  logic [2*NHALF*MXCNTBITS-1:0]  cnt_in;
  logic [2*NHALF-1:0]            vpf_in;
  logic                          ovf_clr;
  logic                          mux_pulse_out;
  logic [NOUT*MXADRBITS-1:0]     adr_o;
  logic [NOUT*MXCNTBITS-1:0]     cnt_o;
  logic [NOUT-1:0]               vpf_o;
  logic                          ovf;
  logic [MXOVFBITS-1:0]          ovf_cnt;
  logic                          malformed;
  modport master (
    output mux_pulse_in, adr_in, cnt_in, vpf_in, ovf_clr,
    input  mux_pulse_out, adr_o, cnt_o, vpf_o, ovf, ovf_cnt, malformed
  );
  modport slave (
    input  mux_pulse_in, adr_in, cnt_in, vpf_in, ovf_clr,
    output mux_pulse_out, adr_o, cnt_o, vpf_o, ovf, ovf_cnt, malformed
  );
endinterface

// File: rtl/merge_light_n_thermo_count.sv
// thermo_count: leading-ones length of a valid vector plus a flag for bits set past the first zero.
module thermo_count import merge_light_n_pkg::*; #(
  parameter int NHALF = 8,
  localparam int KW = $clog2(NHALF + 1)
) (
  input  logic [NHALF-1:0] i_vpf,
  output logic [KW-1:0]    o_len,
  output logic             o_bad
);
  int w_len;
  assign w_len = thermo_len(64'(i_vpf), NHALF);
  assign o_len = KW'(w_len);
  assign o_bad = (64'(i_vpf) >> w_len) != 64'd0;
endmodule

// File: rtl/merge_light_n.sv
// merge_light_n: two-stage merge of a thermometer-packed lower half and a raw upper half into NOUT slots.
module merge_light_n import merge_light_n_pkg::*; #(
  parameter int MXADRBITS = MXADRBITS_DEF,
  parameter int MXCNTBITS = MXCNTBITS_DEF,
  parameter int NHALF = 8,
  parameter int NOUT = 8,
  parameter int MXOVFBITS = 16
) (
  input logic            clock4x,
  input logic            reset_n,
  merge_light_n_if.slave bus
);
  localparam int NIN = 2 * NHALF;
  localparam int KW = $clog2(NHALF + 1);
  logic                      r_pulse1, r_pulse2;
  logic [NIN*MXADRBITS-1:0]  r_adr1;
  logic [NIN*MXCNTBITS-1:0]  r_cnt1;
  logic [NIN-1:0]            r_vpf1;
  logic [NOUT*MXADRBITS-1:0] w_adr, r_adr2;
  logic [NOUT*MXCNTBITS-1:0] w_cnt, r_cnt2;
  logic [NOUT-1:0]           w_vpf, r_vpf2;
  logic [KW-1:0]             w_k;
  logic                      w_bad, w_ovf, r_ovf, r_mal;
  logic [MXOVFBITS-1:0]      r_ovf_cnt;
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_pulse1 <= 1'b0;
      r_adr1 <= '0;
      r_cnt1 <= '0;
      r_vpf1 <= '0;
    end else begin
      r_pulse1 <= bus.mux_pulse_in;
      r_adr1 <= bus.adr_in;
      r_cnt1 <= bus.cnt_in;
      r_vpf1 <= bus.vpf_in;
    end
  end
  thermo_count #(.NHALF(NHALF)) u_thermo (
    .i_vpf(r_vpf1[NHALF-1:0]),
    .o_len(w_k),
    .o_bad(w_bad)
  );
  // Slot j reads lower j inside the run, else upper j-k; past the upper half it stays empty.
  always_comb begin
    w_adr = '0;
    w_cnt = '0;
    w_vpf = '0;
    for (int j = 0; j < NOUT; j++) begin
      int s;
      logic en;
      s = (j < int'(w_k)) ? j : NHALF + j - int'(w_k);
      en = s < NIN;
      w_adr[j*MXADRBITS +: MXADRBITS] = en ? r_adr1[s*MXADRBITS +: MXADRBITS] : '0;
      w_cnt[j*MXCNTBITS +: MXCNTBITS] = en ? r_cnt1[s*MXCNTBITS +: MXCNTBITS] : '0;
      w_vpf[j] = en ? r_vpf1[s] : 1'b0;
    end
  end
  assign w_ovf = (popcount(64'(r_vpf1[NHALF-1:0])) + popcount(64'(r_vpf1[NIN-1:NHALF]))) > NOUT;
  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      r_pulse2 <= 1'b0;
      r_adr2 <= '0;
      r_cnt2 <= '0;
      r_vpf2 <= '0;
      r_ovf <= 1'b0;
      r_mal <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_pulse2 <= r_pulse1;
      r_adr2 <= w_adr;
      r_cnt2 <= w_cnt;
      r_vpf2 <= w_vpf;
      r_ovf <= w_ovf;
      r_mal <= r_mal | w_bad;
      r_ovf_cnt <= bus.ovf_clr ? '0 :
                   (w_ovf && !(&r_ovf_cnt)) ? r_ovf_cnt + MXOVFBITS'(1) : r_ovf_cnt;
    end
  end
  assign bus.mux_pulse_out = r_pulse2;
  assign bus.adr_o = r_adr2;
  assign bus.cnt_o = r_cnt2;
  assign bus.vpf_o = r_vpf2;
  assign bus.ovf = r_ovf;
  assign bus.ovf_cnt = r_ovf_cnt;
  assign bus.malformed = r_mal;
endmodule

// File: tb/tb_merge_light_n.sv
// tb_merge_light_n: table-driven scoreboard bench plus saturation and mid-stream reset sequences.
module tb_merge_light_n;
  localparam int NROW = 9;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  merge_light_n_if #(.MXADRBITS(11), .MXCNTBITS(3), .NHALF(8), .NOUT(8), .MXOVFBITS(16)) bus ();
  merge_light_n #(.MXADRBITS(11), .MXCNTBITS(3), .NHALF(8), .NOUT(8), .MXOVFBITS(16)) dut (
    .clock4x(clk),
    .reset_n(rst_n),
    .bus(bus.slave)
  );
  typedef struct {
    logic [7:0] lv, uv;
    int bl, bu;
    int eadr[8];
    logic [7:0] evpf;
    logic eovf, emal;
  } vec_t;
  typedef struct {
    logic [87:0] adr;
    logic [23:0] cnt;
    logic [7:0] vpf;
    logic ovf, mal, pulse;
    int due;
  } exp_t;
  vec_t tbl[NROW];
  exp_t q[$];
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic zero_in();
    bus.mux_pulse_in = 1'b0;
    bus.adr_in = '0;
    bus.cnt_in = '0;
    bus.vpf_in = '0;
    bus.ovf_clr = 1'b0;
  endtask
  task automatic drive(input int r, input logic p);
    logic [10:0] a;
    bus.mux_pulse_in = p;
    bus.vpf_in = {tbl[r].uv, tbl[r].lv};
    for (int i = 0; i < 8; i++) begin
      a = tbl[r].lv[i] ? 11'(tbl[r].bl + i) : 11'd0;
      bus.adr_in[i*11 +: 11] = a;
      bus.cnt_in[i*3 +: 3] = a[2:0];
      a = tbl[r].uv[i] ? 11'(tbl[r].bu + i) : 11'd0;
      bus.adr_in[(8+i)*11 +: 11] = a;
      bus.cnt_in[(8+i)*3 +: 3] = a[2:0];
    end
  endtask
  function automatic exp_t exp_of(input int r, input logic p, input int due);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      e.adr[j*11 +: 11] = 11'(tbl[r].eadr[j]);
      e.cnt[j*3 +: 3] = 3'(tbl[r].eadr[j] & 7);
    end
    e.vpf = tbl[r].evpf;
    e.ovf = tbl[r].eovf;
    e.mal = tbl[r].emal;
    e.pulse = p;
    e.due = due;
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    int exp_cnt;
    logic exp_mal;
    tbl[0] = '{8'h01, 8'hFF, 5, 100, '{5, 100, 101, 102, 103, 104, 105, 106}, 8'hFF, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 8'h07, 0, 20, '{20, 21, 22, 0, 0, 0, 0, 0}, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 40, 0, '{40, 41, 42, 43, 44, 45, 46, 47}, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h05, 8'h03, 60, 200, '{60, 200, 201, 0, 0, 0, 0, 0}, 8'h07, 1'b0, 1'b1};
    tbl[4] = '{8'h03, 8'hFF, 10, 30, '{10, 11, 30, 31, 32, 33, 34, 35}, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h0F, 8'h0F, 1, 50, '{1, 2, 3, 4, 50, 51, 52, 53}, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h1F, 8'h0F, 1, 50, '{1, 2, 3, 4, 5, 50, 51, 52}, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 8'h00, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{8'h7F, 8'h02, 1, 90, '{1, 2, 3, 4, 5, 6, 7, 0}, 8'h7F, 1'b0, 1'b0};
    rst_n = 1'b0;
    zero_in();
    tick();
    tick();
    chk("reset adr_o", 128'(bus.adr_o), 128'd0);
    chk("reset cnt_o", 128'(bus.cnt_o), 128'd0);
    chk("reset vpf_o", 128'(bus.vpf_o), 128'd0);
    chk("reset ovf", 128'(bus.ovf), 128'd0);
    chk("reset ovf_cnt", 128'(bus.ovf_cnt), 128'd0);
    chk("reset malformed", 128'(bus.malformed), 128'd0);
    chk("reset mux_pulse_out", 128'(bus.mux_pulse_out), 128'd0);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_mal = 1'b0;
    for (int t = 0; t < NROW + 2; t++) begin
      if (q.size() != 0 && q[0].due == t) begin
        e = q.pop_front();
        exp_cnt += int'(e.ovf);
        exp_mal |= e.mal;
        chk($sformatf("row%0d adr_o", t - 2), 128'(bus.adr_o), 128'(e.adr));
        chk($sformatf("row%0d cnt_o", t - 2), 128'(bus.cnt_o), 128'(e.cnt));
        chk($sformatf("row%0d vpf_o", t - 2), 128'(bus.vpf_o), 128'(e.vpf));
        chk($sformatf("row%0d ovf", t - 2), 128'(bus.ovf), 128'(e.ovf));
        chk($sformatf("row%0d ovf_cnt", t - 2), 128'(bus.ovf_cnt), 128'(exp_cnt));
        chk($sformatf("row%0d malformed", t - 2), 128'(bus.malformed), 128'(exp_mal));
        chk($sformatf("row%0d mux_pulse_out", t - 2), 128'(bus.mux_pulse_out), 128'(e.pulse));
      end
      if (t < NROW) begin
        drive(t, t[0]);
        q.push_back(exp_of(t, t[0], t + 2));
      end else zero_in();
      tick();
    end
    chk("scoreboard drained", 128'(q.size()), 128'd0);
    zero_in();
    bus.vpf_in = 16'hFFFF;
    repeat (70000) tick();
    chk("ovf_cnt saturated", 128'(bus.ovf_cnt), 128'hFFFF);
    chk("ovf held", 128'(bus.ovf), 128'd1);
    bus.ovf_clr = 1'b1;
    tick();
    chk("ovf_clr beats increment", 128'(bus.ovf_cnt), 128'd0);
    bus.ovf_clr = 1'b0;
    tick();
    chk("ovf_cnt restarts", 128'(bus.ovf_cnt), 128'd1);
    zero_in();
    repeat (3) tick();
    drive(0, 1'b1);
    tick();
    zero_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset adr_o", 128'(bus.adr_o), 128'd0);
    chk("midreset cnt_o", 128'(bus.cnt_o), 128'd0);
    chk("midreset vpf_o", 128'(bus.vpf_o), 128'd0);
    chk("midreset ovf", 128'(bus.ovf), 128'd0);
    chk("midreset ovf_cnt", 128'(bus.ovf_cnt), 128'd0);
    chk("midreset malformed", 128'(bus.malformed), 128'd0);
    chk("midreset mux_pulse_out", 128'(bus.mux_pulse_out), 128'd0);
    tick();
    chk("post-reset pulse dropped", 128'(bus.mux_pulse_out), 128'd0);
    chk("post-reset vpf_o", 128'(bus.vpf_o), 128'd0);
    drive(2, 1'b1);
    tick();
    zero_in();
    chk("resume latency pulse", 128'(bus.mux_pulse_out), 128'd0);
    tick();
    e = exp_of(2, 1'b1, 0);
    chk("resume adr_o", 128'(bus.adr_o), 128'(e.adr));
    chk("resume cnt_o", 128'(bus.cnt_o), 128'(e.cnt));
    chk("resume vpf_o", 128'(bus.vpf_o), 128'(e.vpf));
    chk("resume mux_pulse_out", 128'(bus.mux_pulse_out), 128'd1);
    chk("resume ovf_cnt", 128'(bus.ovf_cnt), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
